seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Parametrised multiplexed seven-segment display driver: NUM_FIELDS binary values, each shown as FIELD_DIGITS decimal digits on a shared common-select display. A sequential double-dabble converter turns each value into BCD. The block adds leading-zero blanking, overflow indication, PWM brightness and per-field blink. It sits between score/timer logic and the board display pins.

## Interface
- NUM_FIELDS, 2, number of independent values (field 0 is rightmost).
- FIELD_DIGITS, 2, decimal digits per field; total digits D = NUM_FIELDS*FIELD_DIGITS.
- VAL_W, 7, bit width of each value.
- SCAN_DIV, 4096, clocks per digit slot; power of two, >=16.
- BLINK_FRAMES, 64, full scan frames per blink half-period.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- value  in  NUM_FIELDS*VAL_W  packed values; field f at [f*VAL_W +: VAL_W].
- load  in  1  request conversion of the current value bus.
- blank_lz  in  NUM_FIELDS  per-field leading-zero blanking enable.
- blink_en  in  NUM_FIELDS  per-field blink enable.
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
- segment  out  7  {g,f,e,d,c,b,a}, active-high, registered.
- select  out  D  one-hot active-high digit enable, bit 0 = rightmost, registered.
- busy  out  1  converter active.
- done  out  1  one-cycle pulse when new digits are committed.

## Operation
- Converter FSM:
  - IDLE: load=1 captures the value bus into a shadow register, sets field index to 0, and moves to CONV.
  - CONV: runs VAL_W double-dabble shift cycles per field (add 3 to each BCD nibble >=5, then shift). After field NUM_FIELDS-1, moves to COMMIT.
  - COMMIT: writes all D digit registers and the overflow flags simultaneously, pulses done, then returns to IDLE.
- load while busy=1 is ignored; there is no queueing.
- Overflow: a field value > 10**FIELD_DIGITS-1 sets that field's overflow flag. All of the field's digits then display a dash (7'b1000000).
- Leading-zero blanking (blank_lz[f]=1): a digit of field f is blanked if it and every more-significant digit in the field are 0. The field's least-significant digit is never blanked. Overflowed fields are never blanked.
- Blanked digit: select bit is 0 and segment is 0 for that slot.
- Decoder: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Scan: slot counter runs 0..SCAN_DIV-1; digit index i advances 0..D-1 and wraps at each slot rollover.
- PWM: within a slot, select is enabled only while slot_counter[top 4 bits] <= bright.
- Blink: a phase bit toggles every BLINK_FRAMES completed frames. While phase=0, all digits of fields with blink_en=1 are forced dark (select 0, segment 0).
- Reset values:
  - segment=0, select=0, busy=0, done=0.
  - Digit registers all 0; overflow flags 0; FSM in IDLE.
  - Scan, slot and frame counters 0; blink phase=1.
- Asserting rst_n low mid-conversion discards the conversion. Digit registers return to 0 and no done pulse is produced.

## Timing
- load sampled high in IDLE at edge 0:
  - busy=1 from edge 0 through the COMMIT edge.
  - Digits and done update at edge NUM_FIELDS*VAL_W+1; busy=0 at that same edge.
  - With default parameters, latency is 15 cycles.
- The displayed digit changes on the first scan slot evaluated after COMMIT; the display shows no mixed old/new values within a field.
- segment and select are registered together, one clock after the scan/slot counter state that produces them.
- Full frame = D*SCAN_DIV cycles; blink half-period = BLINK_FRAMES*D*SCAN_DIV cycles.
- Blink and PWM gating do not stall scanning or conversion.

## Test plan
- Defaults (SCAN_DIV=16 for sim), value={42,7}, blank_lz=0, bright=15, load pulse:
  - done after 15 cycles.
  - Scan shows slot0 0000111 (select 0001), slot1 0111111 (0010), slot2 1011011 (0100), slot3 1100110 (1000).
- Same values with blank_lz=2'b01 -> slot1 has select=0000 and segment=0; other slots unchanged. Value {0,0} with blank_lz=11 -> only slots 0 and 2 lit, each showing 0111111.
- Value field1=120 (overflow), field0=5 -> slots 2 and 3 show 1000000; slot0 shows 1101101.
- load re-asserted at cycle 5 of a conversion -> ignored; exactly one done pulse, with the original values.
- bright=3 -> select high for 4 of 16 cycles per slot. blink_en=01 with BLINK_FRAMES=1 -> slots 0-1 dark on alternate frames; slots 2-3 unaffected.
- rst_n low at cycle 8 of a conversion -> all outputs are 0 within the same cycle. After release, the display shows the reset digits and no done pulse occurs.

Source files
------------

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: binary fields are converted to BCD by a
// sequential double-dabble engine, then scanned out with blanking, PWM and blink.
module seg_display_mux #(
  parameter int NUM_FIELDS   = 2,
  parameter int FIELD_DIGITS = 2,
  parameter int VAL_W        = 7,
  parameter int SCAN_DIV     = 4096,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_FIELDS*VAL_W-1:0]          value,
  input  logic                                 load,
  input  logic [NUM_FIELDS-1:0]                blank_lz,
  input  logic [NUM_FIELDS-1:0]                blink_en,
  input  logic [3:0]                           bright,
  output logic [6:0]                           segment,
  output logic [NUM_FIELDS*FIELD_DIGITS-1:0]   select,
  output logic                                 busy,
  output logic                                 done
);

  localparam int D      = NUM_FIELDS * FIELD_DIGITS;
  localparam int BCD_W  = FIELD_DIGITS * 4;
  localparam int FI_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BC_W   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int DI_W   = (D > 1) ? $clog2(D) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int MAX_VAL = 10**FIELD_DIGITS - 1;

  localparam logic [FI_W-1:0]   LAST_FIELD = FI_W'(NUM_FIELDS - 1);
  localparam logic [BC_W-1:0]   LAST_BIT   = BC_W'(VAL_W - 1);
  localparam logic [DI_W-1:0]   LAST_DIGIT = DI_W'(D - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = {SLOT_W{1'b1}};
  localparam logic [FR_W-1:0]   LAST_FRAME = FR_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]                  state;
  logic [NUM_FIELDS*VAL_W-1:0] shadow;
  logic [FI_W-1:0]             field_idx;
  logic [FI_W-1:0]             next_field;
  logic [BC_W-1:0]             bit_cnt;
  logic [VAL_W-1:0]            bin;
  logic [BCD_W-1:0]            bcd;
  logic [BCD_W-1:0]            bcd_adj;
  logic [BCD_W-1:0]            bcd_next;
  logic [D*4-1:0]              pend_bcd;
  logic [D*4-1:0]              digits;
  logic [NUM_FIELDS-1:0]       ovf;
  logic [NUM_FIELDS-1:0]       ovf_next;

  logic [SLOT_W-1:0]           slot;
  logic [DI_W-1:0]             scan_idx;
  logic [FR_W-1:0]             frame_cnt;
  logic                        phase;

  logic [D-1:0]                lit;
  logic [D-1:0]                dig_ovf;
  logic                        zero_run;
  logic                        blanked;
  logic [3:0]                  cur_digit;
  logic                        pwm_on;
  logic [6:0]                  seg_next;
  logic [D-1:0]                sel_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // One double-dabble step: correct every nibble, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < FIELD_DIGITS; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
    bcd_next   = {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
    next_field = field_idx + 1'b1;
  end

  always_comb begin
    ovf_next = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      ovf_next[f] = 32'(shadow[f*VAL_W +: VAL_W]) > 32'(MAX_VAL);
    end
  end

  // Digits are staged in pend_bcd and only become visible together at commit,
  // so the scanner never shows a half-updated field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      field_idx <= '0;
      bit_cnt   <= '0;
      bin       <= '0;
      bcd       <= '0;
      pend_bcd  <= '0;
      digits    <= '0;
      ovf       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            shadow    <= value;
            field_idx <= '0;
            bit_cnt   <= '0;
            bin       <= value[VAL_W-1:0];
            bcd       <= '0;
            busy      <= 1'b1;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          bin <= bin << 1;
          bcd <= bcd_next;
          if (bit_cnt == LAST_BIT) begin
            pend_bcd[field_idx*BCD_W +: BCD_W] <= bcd_next;
            bit_cnt <= '0;
            if (field_idx == LAST_FIELD) begin
              state <= S_COMMIT;
            end else begin
              field_idx <= next_field;
              bin       <= shadow[next_field*VAL_W +: VAL_W];
              bcd       <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          digits <= pend_bcd;
          ovf    <= ovf_next;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Blink phase starts lit and flips after every BLINK_FRAMES complete frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      scan_idx  <= '0;
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      slot <= slot + 1'b1;
      if (slot == LAST_SLOT) begin
        if (scan_idx == LAST_DIGIT) begin
          scan_idx <= '0;
          if (frame_cnt == LAST_FRAME) begin
            frame_cnt <= '0;
            phase     <= ~phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

  // Walk each field from its most-significant digit down, tracking an all-zero run.
  always_comb begin
    lit      = '0;
    dig_ovf  = '0;
    zero_run = 1'b1;
    blanked  = 1'b0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      zero_run = 1'b1;
      for (int k = FIELD_DIGITS - 1; k >= 0; k--) begin
        zero_run = zero_run && (digits[(f*FIELD_DIGITS+k)*4 +: 4] == 4'd0);
        blanked  = blank_lz[f] && !ovf[f] && (k != 0) && zero_run;
        lit[f*FIELD_DIGITS+k]     = !blanked && !(blink_en[f] && !phase);
        dig_ovf[f*FIELD_DIGITS+k] = ovf[f];
      end
    end
  end

  always_comb begin
    cur_digit = digits[scan_idx*4 +: 4];
    pwm_on    = slot[SLOT_W-1 -: 4] <= bright;
    seg_next  = 7'b0000000;
    sel_next  = '0;
    if (lit[scan_idx]) begin
      seg_next = dig_ovf[scan_idx] ? 7'b1000000 : decode(cur_digit);
      if (pwm_on) sel_next = {{(D-1){1'b0}}, 1'b1} << scan_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment <= 7'b0000000;
      select  <= '0;
    end else begin
      segment <= seg_next;
      select  <= sel_next;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux; expected scan output is computed
// arithmetically from the field values and elapsed cycles since reset.
module tb_seg_display_mux;

  localparam int NF    = 2;
  localparam int FD    = 2;
  localparam int VW    = 7;
  localparam int SCAN  = 16;
  localparam int BF    = 1;
  localparam int D     = NF * FD;
  localparam int FRAME = SCAN * D;
  localparam int LIMIT = 99;

  localparam logic [6:0] DEC [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                      7'b1111111, 7'b1101111};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NF*VW-1:0] value = '0;
  logic            load = 1'b0;
  logic [NF-1:0]   blank_lz = '0;
  logic [NF-1:0]   blink_en = '0;
  logic [3:0]      bright = 4'hF;
  logic [6:0]      segment;
  logic [D-1:0]    select;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          m_vals [NF];
  logic [NF-1:0] m_blank = '0;
  logic [NF-1:0] m_blink = '0;
  int          m_bright = 15;

  seg_display_mux #(
    .NUM_FIELDS(NF), .FIELD_DIGITS(FD), .VAL_W(VW), .SCAN_DIV(SCAN), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .bright(bright), .segment(segment), .select(select),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release; drives the reference scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [NF*VW-1:0] pack(input int a1, input int a0);
    logic [VW-1:0] x1, x0;
    x1 = a1[VW-1:0];
    x0 = a0[VW-1:0];
    return {x1, x0};
  endfunction

  // Expected {segment, select} produced from the counter state reached after t clocks.
  function automatic logic [6+D:0] exp_out(input int t);
    int slot, i, f, k, v, p10;
    logic phase, ovf, blank, dark;
    logic [6:0] seg;
    logic [D-1:0] sel;
    slot  = t % SCAN;
    i     = (t / SCAN) % D;
    phase = ((t / (FRAME * BF)) % 2) == 0;
    f = i / FD;
    k = i % FD;
    v = m_vals[f];
    p10 = 1;
    for (int j = 0; j < k; j++) p10 = p10 * 10;
    ovf   = v > LIMIT;
    blank = m_blank[f] && !ovf && (k > 0) && (v < p10);
    dark  = blank || (m_blink[f] && !phase);
    if (dark) seg = 7'b0;
    else if (ovf) seg = 7'b1000000;
    else seg = DEC[(v / p10) % 10];
    sel = '0;
    if (!dark && ((slot * 16) / SCAN) <= m_bright) sel[i] = 1'b1;
    return {seg, sel};
  endfunction

  task automatic run_load(input int f1, input int f0, output int lat, output int busy_hi);
    value = pack(f1, f0);
    load  = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    lat     = 0;
    busy_hi = 0;
    while (lat < 100) begin
      if (busy === 1'b1) busy_hi++;
      @(negedge clk);
      lat++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    logic [6+D:0] exp;
    rst_n = 1'b0;
    m_vals[0] = 0; m_vals[1] = 0;
    m_blank = '0; m_blink = '0; m_bright = 15;
    repeat (3) @(negedge clk);
    n_checks++;
    if (segment !== 7'b0) begin n_fail++; $display("[TB] FAIL reset_segment got %b exp 0", segment); end
    n_checks++;
    if (select !== '0) begin n_fail++; $display("[TB] FAIL reset_select got %b exp 0", select); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
  endtask

  task automatic test_convert();
    int lat, bh;
    logic [6+D:0] exp;
    run_load(42, 7, lat, bh);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("[TB] FAIL convert_latency got %0d exp 15", lat); end
    n_checks++;
    if (bh !== 15) begin n_fail++; $display("[TB] FAIL convert_busy_cycles got %0d exp 15", bh); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL convert_busy_at_done got %b exp 0", busy); end
    m_vals[1] = 42; m_vals[0] = 7;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL convert_done_pulse got %b exp 0", done); end
    @(negedge clk);
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL convert_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
  endtask

  task automatic test_blanking();
    int lat, bh;
    logic [6+D:0] exp;
    blank_lz = 2'b01; m_blank = 2'b01;
    repeat (2) @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL blank_42_7 t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
    blank_lz = 2'b11; m_blank = 2'b11;
    run_load(0, 0, lat, bh);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("[TB] FAIL blank_latency got %0d exp 15", lat); end
    m_vals[1] = 0; m_vals[0] = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL blank_zero t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat, bh;
    int v1 [2] = '{120, 100};
    int v0 [2] = '{5, 99};
    logic [6+D:0] exp;
    for (int r = 0; r < 2; r++) begin
      blank_lz = (r == 0) ? 2'b10 : 2'b11;
      m_blank  = blank_lz;
      run_load(v1[r], v0[r], lat, bh);
      n_checks++;
      if (lat !== 15) begin n_fail++; $display("[TB] FAIL ovf_latency got %0d exp 15", lat); end
      m_vals[1] = v1[r]; m_vals[0] = v0[r];
      repeat (2) @(negedge clk);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        exp = exp_out(cyc - 1);
        n_checks++;
        if ({segment, select} !== exp) begin
          n_fail++;
          $display("[TB] FAIL ovf_scan v=%0d,%0d t=%0d got %b/%b exp %b/%b", v1[r], v0[r], cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
        end
      end
    end
    blank_lz = 2'b00; m_blank = 2'b00;
  endtask

  task automatic test_load_ignored();
    int dones, first;
    logic [6+D:0] exp;
    value = pack(13, 88);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    dones = 0;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) begin value = pack(77, 66); load = 1'b1; end
      else load = 1'b0;
      if (done === 1'b1) begin dones++; if (first < 0) first = c; end
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("[TB] FAIL ignore_done_count got %0d exp 1", dones); end
    n_checks++;
    if (first !== 15) begin n_fail++; $display("[TB] FAIL ignore_done_cycle got %0d exp 15", first); end
    m_vals[1] = 13; m_vals[0] = 88;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL ignore_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bh, a1, a0;
    logic [6+D:0] exp;
    for (int r = 0; r < 4; r++) begin
      a1 = $urandom_range(0, 127);
      a0 = $urandom_range(0, 127);
      blank_lz = 2'($urandom_range(0, 3));
      bright   = 4'($urandom_range(0, 15));
      m_blank  = blank_lz;
      m_bright = int'(bright);
      run_load(a1, a0, lat, bh);
      n_checks++;
      if (lat !== 15) begin n_fail++; $display("[TB] FAIL rand_latency got %0d exp 15", lat); end
      m_vals[1] = a1; m_vals[0] = a0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        exp = exp_out(cyc - 1);
        n_checks++;
        if ({segment, select} !== exp) begin
          n_fail++;
          $display("[TB] FAIL rand_scan v=%0d,%0d t=%0d got %b/%b exp %b/%b", a1, a0, cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
        end
      end
    end
    blank_lz = 2'b00; m_blank = 2'b00;
    bright = 4'hF; m_bright = 15;
  endtask

  task automatic test_pwm();
    int on_cnt, guard;
    logic [6+D:0] exp;
    bright = 4'd3; m_bright = 3;
    repeat (2) @(negedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL pwm_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
    guard = 0;
    while (((cyc - 1) % SCAN) != SCAN - 1 && guard < SCAN + 2) begin
      @(negedge clk);
      guard++;
    end
    on_cnt = 0;
    for (int c = 0; c < SCAN; c++) begin
      @(negedge clk);
      if (select !== '0) on_cnt++;
    end
    n_checks++;
    if (on_cnt !== 4) begin n_fail++; $display("[TB] FAIL pwm_duty got %0d exp 4", on_cnt); end
    bright = 4'hF; m_bright = 15;
  endtask

  task automatic test_blink();
    logic [6+D:0] exp;
    blink_en = 2'b01; m_blink = 2'b01;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL blink_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
    blink_en = 2'b00; m_blink = 2'b00;
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [6+D:0] exp;
    value = pack(55, 33);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (segment !== 7'b0) begin n_fail++; $display("[TB] FAIL midrst_segment got %b exp 0", segment); end
    n_checks++;
    if (select !== '0) begin n_fail++; $display("[TB] FAIL midrst_select got %b exp 0", select); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got %b exp 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done got %b exp 0", done); end
    m_vals[1] = 0; m_vals[0] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < FRAME + 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      exp = exp_out(cyc - 1);
      n_checks++;
      if ({segment, select} !== exp) begin
        n_fail++;
        $display("[TB] FAIL midrst_scan t=%0d got %b/%b exp %b/%b", cyc - 1, segment, select, exp[6+D:D], exp[D-1:0]);
      end
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_done got %0d exp 0", dones); end
  endtask

  initial begin
    $display("[TB] seg_display_mux bench start");
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_load_ignored();
    test_random();
    test_pwm();
    test_blink();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
